// File: rtl/ble_result_receiver.sv
// Receives 8N1 UART bytes from the BLE module, parses 4-byte A5/class/score/chk
// result packets and drives a held owner-detected flag.
module ble_result_receiver #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned THRESHOLD    = 128,
  parameter int unsigned HOLD_CYCLES  = 100_000_000,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ble_uart_rx_in,
  output logic       detected_out,
  output logic       result_valid_out,
  output logic [7:0] result_class_out,
  output logic [7:0] result_score_out,
  output logic       error_out
);

  localparam int unsigned CW        = $clog2(CLKS_PER_BIT);
  localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TW        = $clog2(TMO_LIMIT + 1);
  localparam int unsigned HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_LIMIT - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [8:0]    THRESH    = 9'(THRESHOLD);
  localparam logic [7:0]    HDR       = 8'hA5;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;
  typedef enum logic [1:0] {P_WAIT_HDR, P_GET_CLASS, P_GET_SCORE, P_GET_CHK} parse_state_e;

  // Synchroniser and edge history reset low so a start bit needs the line seen high first.
  logic sync1_q, rx_s_q, rx_prev_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q   <= 1'b0;
      rx_s_q    <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      sync1_q   <= ble_uart_rx_in;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  uart_state_e   ustate_q, ustate_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;

  always_comb begin
    ustate_d     = ustate_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (ustate_q)
      U_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          ustate_d = U_START;
          cnt_d    = '0;
        end
      end
      U_START: begin
        if (cnt_q == CNT_HALF) begin
          if (!rx_s_q) begin
            ustate_d = U_DATA;
            cnt_d    = '0;
            bit_d    = '0;
          end else begin
            ustate_d = U_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      U_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_q == 3'd7) ustate_d = U_STOP;
          else               bit_d    = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      U_STOP: begin
        if (cnt_q == CNT_LAST) begin
          ustate_d = U_IDLE;
          cnt_d    = '0;
          if (rx_s_q) byte_valid_d = 1'b1;
          else        frame_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ustate_q     <= U_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      ustate_q     <= ustate_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  parse_state_e  pstate_q, pstate_d;
  logic [7:0]    cls_q, cls_d, scr_q, scr_d;
  logic [7:0]    rclass_q, rclass_d, rscore_q, rscore_d;
  logic          rvalid_q, rvalid_d, error_q, error_d, det_q, det_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [HW-1:0] hold_q, hold_d;

  always_comb begin
    pstate_d = pstate_q;
    cls_d    = cls_q;
    scr_d    = scr_q;
    rclass_d = rclass_q;
    rscore_d = rscore_q;
    rvalid_d = 1'b0;
    error_d  = 1'b0;
    det_d    = det_q;
    hold_d   = hold_q;
    tmo_d    = (pstate_q == P_WAIT_HDR) ? '0 : tmo_q + 1'b1;

    if (hold_q != '0) hold_d = hold_q - 1'b1;
    else              det_d  = 1'b0;

    if (frame_err_q) begin
      error_d  = 1'b1;
      pstate_d = P_WAIT_HDR;
      tmo_d    = '0;
    end else if (byte_valid_q) begin
      tmo_d = '0;
      unique case (pstate_q)
        P_WAIT_HDR:  if (shift_q == HDR) pstate_d = P_GET_CLASS;
        P_GET_CLASS: begin
          cls_d    = shift_q;
          pstate_d = P_GET_SCORE;
        end
        P_GET_SCORE: begin
          scr_d    = shift_q;
          pstate_d = P_GET_CHK;
        end
        P_GET_CHK: begin
          pstate_d = P_WAIT_HDR;
          if ((shift_q != (HDR ^ cls_q ^ scr_q)) || (cls_q[7:1] != '0)) begin
            error_d = 1'b1;
          end else begin
            rvalid_d = 1'b1;
            rclass_d = cls_q;
            rscore_d = scr_q;
            // Detection decision overrides the hold countdown in the accept cycle.
            if (cls_q[0] && ({1'b0, scr_q} >= THRESH)) begin
              det_d  = 1'b1;
              hold_d = HOLD_LOAD;
            end else begin
              det_d  = 1'b0;
              hold_d = '0;
            end
          end
        end
      endcase
    end else if ((pstate_q != P_WAIT_HDR) && (tmo_q == TMO_LAST)) begin
      error_d  = 1'b1;
      pstate_d = P_WAIT_HDR;
      tmo_d    = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pstate_q <= P_WAIT_HDR;
      cls_q    <= '0;
      scr_q    <= '0;
      rclass_q <= '0;
      rscore_q <= '0;
      rvalid_q <= 1'b0;
      error_q  <= 1'b0;
      det_q    <= 1'b0;
      tmo_q    <= '0;
      hold_q   <= '0;
    end else begin
      pstate_q <= pstate_d;
      cls_q    <= cls_d;
      scr_q    <= scr_d;
      rclass_q <= rclass_d;
      rscore_q <= rscore_d;
      rvalid_q <= rvalid_d;
      error_q  <= error_d;
      det_q    <= det_d;
      tmo_q    <= tmo_d;
      hold_q   <= hold_d;
    end
  end

  assign detected_out     = det_q;
  assign result_valid_out = rvalid_q;
  assign result_class_out = rclass_q;
  assign result_score_out = rscore_q;
  assign error_out        = error_q;

endmodule

// File: tb/tb_ble_result_receiver.sv
// Bench for ble_result_receiver: serialises packets onto the UART line and
// compares the decoded results against a byte-level packet model.
module tb_ble_result_receiver;
  localparam int CPB  = 16;
  localparam int HOLD = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       det, rv, err;
  logic [7:0] rcls, rscr;

  ble_result_receiver #(
    .CLKS_PER_BIT(CPB), .THRESHOLD(128), .HOLD_CYCLES(HOLD), .TIMEOUT_BITS(20)
  ) dut (
    .clk_in(clk), .rst_in(rst), .ble_uart_rx_in(rx),
    .detected_out(det), .result_valid_out(rv), .result_class_out(rcls),
    .result_score_out(rscr), .error_out(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Event monitor, sampled on the falling edge.
  int   rv_cnt = 0, err_cnt = 0, rise_cnt = 0, fall_cnt = 0;
  int   last_rv_cyc = 0, last_err_cyc = 0, rise_cyc = 0, fall_cyc = 0;
  logic det_prev = 1'b0;
  always @(negedge clk) begin
    if (rv === 1'b1) begin rv_cnt++; last_rv_cyc = cyc; end
    if (err === 1'b1) begin err_cnt++; last_err_cyc = cyc; end
    if (det === 1'b1 && det_prev !== 1'b1) begin rise_cnt++; rise_cyc = cyc; end
    if (det !== 1'b1 && det_prev === 1'b1) begin fall_cnt++; fall_cyc = cyc; end
    det_prev = det;
  end

  // Packet-level reference model.
  int         m_state = 0;
  logic [7:0] m_cls = '0, m_scr = '0;
  int         exp_rv = 0, exp_err = 0;
  logic [7:0] exp_cls = '0, exp_scr = '0;
  logic       exp_match = 1'b0;

  task automatic model_byte(input logic [7:0] b);
    case (m_state)
      0: if (b == 8'hA5) m_state = 1;
      1: begin m_cls = b; m_state = 2; end
      2: begin m_scr = b; m_state = 3; end
      default: begin
        m_state = 0;
        if (b != (8'hA5 ^ m_cls ^ m_scr) || m_cls > 8'd1) exp_err++;
        else begin
          exp_rv++;
          exp_cls   = m_cls;
          exp_scr   = m_scr;
          exp_match = (m_cls == 8'd1) && (m_scr >= 8'd128);
        end
      end
    endcase
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(stop_ok, CPB);
    drive(1'b1, 2);
    if (stop_ok) model_byte(b);
    else begin m_state = 0; exp_err++; end
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    send_byte(a); send_byte(b); send_byte(c); send_byte(d);
    drive(1'b1, 4);
  endtask

  task automatic wait_fall(input int f0, input int budget);
    for (int i = 0; i < budget && fall_cnt == f0; i++) drive(1'b1, 1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, 3);
    n_checks++; if (det !== 1'b0) begin n_errors++; $display("FAIL reset_det: got %b want 0", det); end
    n_checks++; if (rv !== 1'b0) begin n_errors++; $display("FAIL reset_rv: got %b want 0", rv); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if ({rcls, rscr} !== 16'h0) begin n_errors++; $display("FAIL reset_result: got %h/%h want 00/00", rcls, rscr); end
    rst = 1'b0;
    drive(1'b1, 4);
  endtask

  task automatic test_owner_match;
    int f0;
    f0 = fall_cnt;
    send_pkt(8'hA5, 8'h01, 8'hC8, 8'h6C);
    n_checks++; if (rv_cnt !== exp_rv) begin n_errors++; $display("FAIL owner_rv_count: got %0d want %0d", rv_cnt, exp_rv); end
    n_checks++; if (rcls !== 8'h01) begin n_errors++; $display("FAIL owner_class: got %h want 01", rcls); end
    n_checks++; if (rscr !== 8'hC8) begin n_errors++; $display("FAIL owner_score: got %h want c8", rscr); end
    n_checks++; if (err_cnt !== exp_err) begin n_errors++; $display("FAIL owner_err_count: got %0d want %0d", err_cnt, exp_err); end
    n_checks++; if (det !== 1'b1) begin n_errors++; $display("FAIL owner_det_high: got %b want 1", det); end
    n_checks++; if (rise_cyc !== last_rv_cyc) begin n_errors++; $display("FAIL owner_rise_cycle: got %0d want %0d", rise_cyc, last_rv_cyc); end
    wait_fall(f0, HOLD + 200);
    n_checks++; if (fall_cnt !== f0 + 1) begin n_errors++; $display("FAIL owner_hold_expiry: got %0d falls want %0d", fall_cnt - f0, 1); end
    n_checks++; if (fall_cyc - rise_cyc !== HOLD) begin n_errors++; $display("FAIL owner_hold_length: got %0d want %0d", fall_cyc - rise_cyc, HOLD); end
  endtask

  task automatic test_low_score;
    int r0;
    r0 = rise_cnt;
    send_pkt(8'hA5, 8'h01, 8'h40, 8'hE4);
    n_checks++; if (rv_cnt !== exp_rv) begin n_errors++; $display("FAIL low_rv_count: got %0d want %0d", rv_cnt, exp_rv); end
    n_checks++; if (rscr !== 8'h40) begin n_errors++; $display("FAIL low_score: got %h want 40", rscr); end
    n_checks++; if (err_cnt !== exp_err) begin n_errors++; $display("FAIL low_err_count: got %0d want %0d", err_cnt, exp_err); end
    n_checks++; if (rise_cnt !== r0 || det !== 1'b0) begin n_errors++; $display("FAIL low_det: got det=%b rises=%0d want det=0 rises=0", det, rise_cnt - r0); end
  endtask

  task automatic test_reject_while_held;
    int f0, r1, r2;
    f0 = fall_cnt;
    send_pkt(8'hA5, 8'h01, 8'hC8, 8'h6C);
    r1 = last_rv_cyc;
    for (int i = 0; i < 400 && cyc < r1 + 200; i++) drive(1'b1, 1);
    send_pkt(8'hA5, 8'h00, 8'h00, 8'hA5);
    n_checks++; if (rv_cnt !== exp_rv) begin n_errors++; $display("FAIL reject_rv_count: got %0d want %0d", rv_cnt, exp_rv); end
    n_checks++; if (fall_cnt !== f0 + 1 || fall_cyc !== last_rv_cyc) begin n_errors++; $display("FAIL reject_drop_cycle: got fall@%0d want fall@%0d", fall_cyc, last_rv_cyc); end
    n_checks++; if (det !== 1'b0) begin n_errors++; $display("FAIL reject_det: got %b want 0", det); end
    // Retrigger shortly before expiry extends the high time.
    f0 = fall_cnt;
    send_pkt(8'hA5, 8'h01, 8'hC8, 8'h6C);
    r1 = last_rv_cyc;
    for (int i = 0; i < 400 && cyc < r1 + 250; i++) drive(1'b1, 1);
    send_pkt(8'hA5, 8'h01, 8'hFF, 8'h5B);
    r2 = last_rv_cyc;
    n_checks++; if (fall_cnt !== f0 || det !== 1'b1) begin n_errors++; $display("FAIL retrig_still_high: got det=%b falls=%0d want det=1 falls=0", det, fall_cnt - f0); end
    wait_fall(f0, HOLD + 200);
    n_checks++; if (fall_cyc - r1 !== (r2 - r1) + HOLD) begin n_errors++; $display("FAIL retrig_high_time: got %0d want %0d", fall_cyc - r1, (r2 - r1) + HOLD); end
    n_checks++; if (rise_cyc !== r1) begin n_errors++; $display("FAIL retrig_single_rise: got rise@%0d want rise@%0d", rise_cyc, r1); end
  endtask

  task automatic test_bad_packets;
    send_pkt(8'hA5, 8'h01, 8'hC8, 8'h00);
    n_checks++; if (err_cnt !== exp_err) begin n_errors++; $display("FAIL badchk_err_count: got %0d want %0d", err_cnt, exp_err); end
    n_checks++; if (rv_cnt !== exp_rv) begin n_errors++; $display("FAIL badchk_rv_count: got %0d want %0d", rv_cnt, exp_rv); end
    n_checks++; if (rcls !== exp_cls || rscr !== exp_scr || det !== 1'b0) begin n_errors++; $display("FAIL badchk_outputs: got %h/%h det=%b want %h/%h det=0", rcls, rscr, det, exp_cls, exp_scr); end
    send_pkt(8'hA5, 8'h07, 8'hC8, 8'h6A);
    n_checks++; if (err_cnt !== exp_err || rv_cnt !== exp_rv) begin n_errors++; $display("FAIL badclass: got err=%0d rv=%0d want err=%0d rv=%0d", err_cnt, rv_cnt, exp_err, exp_rv); end
    send_byte(8'h3C); send_byte(8'hFF);
    send_pkt(8'hA5, 8'h01, 8'hC8, 8'h6C);
    n_checks++; if (err_cnt !== exp_err) begin n_errors++; $display("FAIL junk_no_error: got %0d want %0d", err_cnt, exp_err); end
    n_checks++; if (rv_cnt !== exp_rv || rcls !== 8'h01 || rscr !== 8'hC8) begin n_errors++; $display("FAIL junk_accept: got rv=%0d %h/%h want rv=%0d 01/c8", rv_cnt, rcls, rscr, exp_rv); end
  endtask

  task automatic test_line_faults;
    int t_end, e0;
    // Detector is high from the previous packet; a framing error must not touch it.
    send_byte(8'hA5, 1'b0);
    drive(1'b1, 4);
    n_checks++; if (err_cnt !== exp_err) begin n_errors++; $display("FAIL frame_err_count: got %0d want %0d", err_cnt, exp_err); end
    n_checks++; if (det !== 1'b1) begin n_errors++; $display("FAIL frame_det_kept: got %b want 1", det); end
    send_byte(8'h01); send_byte(8'hC8); send_byte(8'h6C);
    drive(1'b1, 4);
    n_checks++; if (rv_cnt !== exp_rv) begin n_errors++; $display("FAIL frame_no_packet: got %0d want %0d", rv_cnt, exp_rv); end
    drive(1'b0, 4);
    drive(1'b1, 40);
    n_checks++; if (err_cnt !== exp_err || rv_cnt !== exp_rv) begin n_errors++; $display("FAIL glitch: got err=%0d rv=%0d want err=%0d rv=%0d", err_cnt, rv_cnt, exp_err, exp_rv); end
    e0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h01);
    t_end = cyc;
    drive(1'b1, 400);
    m_state = 0; exp_err++;
    n_checks++; if (err_cnt !== exp_err) begin n_errors++; $display("FAIL timeout_err_count: got %0d want %0d", err_cnt, exp_err); end
    n_checks++; if (err_cnt == e0 || last_err_cyc - t_end < 305 || last_err_cyc - t_end > 325) begin n_errors++; $display("FAIL timeout_latency: got %0d want 305..325", last_err_cyc - t_end); end
    send_pkt(8'hA5, 8'h01, 8'h80, 8'h24);
    n_checks++; if (rv_cnt !== exp_rv || rscr !== 8'h80 || det !== 1'b1) begin n_errors++; $display("FAIL timeout_recover: got rv=%0d score=%h det=%b want rv=%0d score=80 det=1", rv_cnt, rscr, det, exp_rv); end
  endtask

  task automatic test_reset_mid_packet;
    send_byte(8'hA5); send_byte(8'h01);
    rst = 1'b1;
    drive(1'b1, 1);
    rst = 1'b0;
    m_state = 0; exp_cls = '0; exp_scr = '0;
    n_checks++; if ({det, rv, err, rcls, rscr} !== 19'h0) begin n_errors++; $display("FAIL midrst_outputs: got det=%b rv=%b err=%b %h/%h want all 0", det, rv, err, rcls, rscr); end
    drive(1'b1, 4);
    send_pkt(8'hA5, 8'h00, 8'h33, 8'h96);
    n_checks++; if (rv_cnt !== exp_rv || rcls !== 8'h00 || rscr !== 8'h33) begin n_errors++; $display("FAIL midrst_next_pkt: got rv=%0d %h/%h want rv=%0d 00/33", rv_cnt, rcls, rscr, exp_rv); end
    n_checks++; if (err_cnt !== exp_err || det !== 1'b0) begin n_errors++; $display("FAIL midrst_err_det: got err=%0d det=%b want err=%0d det=0", err_cnt, det, exp_err); end
  endtask

  task automatic test_random_packets;
    logic [7:0] c, s, k;
    int kind, rv0;
    for (int n = 0; n < 14; n++) begin
      kind = $urandom_range(0, 3);
      c = 8'($urandom_range(0, 1));
      s = 8'($urandom_range(0, 255));
      if (kind == 2) c = 8'($urandom_range(2, 255));
      k = 8'hA5 ^ c ^ s;
      if (kind == 1) k = k ^ 8'($urandom_range(1, 255));
      if (kind == 3) send_byte(8'($urandom_range(0, 164)));
      rv0 = exp_rv;
      send_pkt(8'hA5, c, s, k);
      n_checks++; if (rv_cnt !== exp_rv || err_cnt !== exp_err) begin n_errors++; $display("FAIL rand%0d_counts: got rv=%0d err=%0d want rv=%0d err=%0d", n, rv_cnt, err_cnt, exp_rv, exp_err); end
      n_checks++; if (rcls !== exp_cls || rscr !== exp_scr) begin n_errors++; $display("FAIL rand%0d_result: got %h/%h want %h/%h", n, rcls, rscr, exp_cls, exp_scr); end
      if (exp_rv != rv0) begin
        n_checks++; if (det !== exp_match) begin n_errors++; $display("FAIL rand%0d_det: got %b want %b", n, det, exp_match); end
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_owner_match();
    test_low_score();
    test_reject_while_held();
    test_bad_packets();
    test_line_faults();
    test_reset_mid_packet();
    test_random_packets();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit after %0d checks", n_checks);
    $fatal(1);
  end
endmodule
